// File: rtl/hdmi_island.sv
// HDMI data island generator: buffers packets in a FIFO and emits preamble,
// guard bands and TERC4-coded packet symbols (header + BCH ECC) on demand.
module hdmi_island #(
  parameter int NPKT_MAX   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hsync,
  input  logic         vsync,
  input  logic         start,
  input  logic         pkt_valid,
  output logic         pkt_ready,
  input  logic [23:0]  pkt_hdr,
  input  logic [223:0] pkt_body,
  output logic         island_en,
  output logic [29:0]  d,
  output logic         busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [9:0] PRE_CH   = 10'b0010101011;
  localparam logic [9:0] GUARD_CH = 10'b0100110011;

  // state names the symbol currently on d; cnt is its index inside the phase
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_LGUARD, S_PKT, S_TGUARD} state_t;

  function automatic logic [9:0] terc4(input logic [3:0] v);
    case (v)
      4'h0: terc4 = 10'b1010011100;
      4'h1: terc4 = 10'b1001100011;
      4'h2: terc4 = 10'b1011100100;
      4'h3: terc4 = 10'b1011100010;
      4'h4: terc4 = 10'b0101110001;
      4'h5: terc4 = 10'b0100011110;
      4'h6: terc4 = 10'b0110001110;
      4'h7: terc4 = 10'b0100111100;
      4'h8: terc4 = 10'b1011001100;
      4'h9: terc4 = 10'b0100111001;
      4'ha: terc4 = 10'b0110011100;
      4'hb: terc4 = 10'b1011000110;
      4'hc: terc4 = 10'b1010001110;
      4'hd: terc4 = 10'b1001110001;
      4'he: terc4 = 10'b0101100011;
      default: terc4 = 10'b1011000011;
    endcase
  endfunction

  function automatic logic [9:0] ctrl_code(input logic [1:0] v);
    case (v)
      2'b00: ctrl_code = 10'b1101010100;
      2'b01: ctrl_code = 10'b0010101011;
      2'b10: ctrl_code = 10'b0101010100;
      default: ctrl_code = 10'b1010101011;
    endcase
  endfunction

  function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
    ecc_step = (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
  endfunction

  // packet FIFO; pkt_ready reflects occupancy before any same-cycle pop
  logic [247:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  logic [247:0]  head;

  assign pkt_ready = (count != CW'(FIFO_DEPTH));
  assign push      = pkt_valid && pkt_ready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pkt_hdr, pkt_body};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // sequencer
  state_t     state, nxt_state;
  logic [4:0] cnt, nxt_cnt, pkt_rem, nxt_pkt_rem, n_latch;
  logic       first_pkt, nxt_first;

  always_comb begin
    if (int'(count) < NPKT_MAX) n_latch = 5'(count);
    else                        n_latch = 5'(NPKT_MAX);
  end

  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_pkt_rem = pkt_rem;
    nxt_first   = first_pkt;
    pop         = 1'b0;
    case (state)
      S_IDLE:
        if (start && count != '0) begin
          nxt_state   = S_PRE;
          nxt_cnt     = 5'd0;
          nxt_pkt_rem = n_latch;
          nxt_first   = 1'b1;
        end
      S_PRE:
        if (cnt == 5'd7) begin
          nxt_state = S_LGUARD;
          nxt_cnt   = 5'd0;
        end else nxt_cnt = cnt + 5'd1;
      S_LGUARD:
        if (cnt == 5'd1) begin
          nxt_state = S_PKT;
          nxt_cnt   = 5'd0;
        end else begin
          nxt_cnt = cnt + 5'd1;
          pop     = 1'b1;
        end
      S_PKT:
        if (cnt == 5'd31) begin
          nxt_cnt = 5'd0;
          if (pkt_rem > 5'd1) begin
            nxt_pkt_rem = pkt_rem - 5'd1;
            nxt_first   = 1'b0;
          end else nxt_state = S_TGUARD;
        end else begin
          nxt_cnt = cnt + 5'd1;
          // the next packet is loaded while the last symbol of this one is shown
          if (cnt == 5'd30 && pkt_rem > 5'd1) pop = 1'b1;
        end
      S_TGUARD:
        if (cnt == 5'd1) nxt_state = S_IDLE;
        else nxt_cnt = cnt + 5'd1;
      default: nxt_state = S_IDLE;
    endcase
  end

  // shift registers plus running ECC for the header and four subpackets
  logic [23:0]       hdr_sr;
  logic [7:0]        hecc;
  logic [3:0][55:0]  sub_sr;
  logic [3:0][7:0]   secc;

  always_ff @(posedge clk) begin
    if (pop) begin
      hdr_sr <= head[247:224];
      sub_sr <= head[223:0];
      hecc   <= '0;
      secc   <= '0;
    end else if (nxt_state == S_PKT) begin
      if (nxt_cnt < 5'd24) begin
        hecc   <= ecc_step(hecc, hdr_sr[0]);
        hdr_sr <= hdr_sr >> 1;
      end else hecc <= hecc >> 1;
      for (int k = 0; k < 4; k++) begin
        if (nxt_cnt < 5'd28) begin
          secc[k]   <= ecc_step(ecc_step(secc[k], sub_sr[k][0]), sub_sr[k][1]);
          sub_sr[k] <= sub_sr[k] >> 2;
        end else secc[k] <= secc[k] >> 2;
      end
    end
  end

  logic [1:0]  ctl;
  logic        b3, hbit;
  logic [3:0]  ev, od;
  logic [29:0] sym;

  always_comb begin
    ctl  = {vsync, hsync};
    b3   = ~(nxt_first & (nxt_cnt == 5'd0));
    hbit = (nxt_cnt < 5'd24) ? hdr_sr[0] : hecc[0];
    ev   = '0;
    od   = '0;
    for (int k = 0; k < 4; k++) begin
      ev[k] = (nxt_cnt < 5'd28) ? sub_sr[k][0] : secc[k][0];
      od[k] = (nxt_cnt < 5'd28) ? sub_sr[k][1] : secc[k][1];
    end
    case (nxt_state)
      S_PRE:              sym = {PRE_CH, PRE_CH, ctrl_code(ctl)};
      S_LGUARD, S_TGUARD: sym = {GUARD_CH, GUARD_CH, terc4({2'b11, ctl})};
      S_PKT:              sym = {terc4(od), terc4(ev), terc4({b3, hbit, ctl})};
      default:            sym = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pkt_rem   <= '0;
      first_pkt <= 1'b0;
      d         <= '0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      pkt_rem   <= nxt_pkt_rem;
      first_pkt <= nxt_first;
      d         <= sym;
    end
  end

  assign busy      = (state != S_IDLE);
  assign island_en = busy;

endmodule

// File: tb/tb_hdmi_island.sv
// Self-checking bench for hdmi_island: table-driven symbol checks, directed
// multi-cycle sequences and randomized islands against a packet-level model.
module tb_hdmi_island;
  localparam int NPKT_MAX   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam logic [9:0] PRE_CH   = 10'b0010101011;
  localparam logic [9:0] GUARD_CH = 10'b0100110011;

  logic         clk = 1'b0;
  logic         rst, hsync, vsync, start, pkt_valid, pkt_ready, island_en, busy;
  logic [23:0]  pkt_hdr;
  logic [223:0] pkt_body;
  logic [29:0]  d;

  hdmi_island #(.NPKT_MAX(NPKT_MAX), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .start(start),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_hdr(pkt_hdr),
    .pkt_body(pkt_body), .island_en(island_en), .d(d), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [29:0]  exp_q[$];
  logic [29:0]  obs_d[$];
  logic [23:0]  mq_hdr[$];
  logic [223:0] mq_body[$];
  logic [1:0]   sync_seq [0:127];
  logic [9:0]   terc4_tab [16];
  logic [9:0]   ctrl_tab [4];
  int           last_len;

  typedef struct {
    logic [1:0] vh;
    logic [9:0] pre0;
    logic [9:0] grd0;
    logic [9:0] pkt0;
    logic [9:0] pkt1;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ecc_of(input logic [63:0] bits, input int n);
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < n; i++) e = (e >> 1) ^ ((e[0] ^ bits[i]) ? 8'h83 : 8'h00);
    return e;
  endfunction

  function automatic logic [223:0] rand_body();
    logic [223:0] b;
    for (int i = 0; i < 7; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // driver: one packet, accepted at the next edge
  task automatic push_pkt(input logic [23:0] h, input logic [223:0] b);
    pkt_valid = 1'b1;
    pkt_hdr   = h;
    pkt_body  = b;
    check("push_ready", pkt_ready, 1);
    step;
    mq_hdr.push_back(h);
    mq_body.push_back(b);
    pkt_valid = 1'b0;
  endtask

  // reference: whole island as a list of symbols, from the packet contents
  task automatic build_expected(input int n);
    int k;
    logic [23:0]  h;
    logic [223:0] b;
    logic [31:0]  hs;
    logic [63:0]  sub [4];
    logic [3:0]   c1, c2;
    logic         b3;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({PRE_CH, PRE_CH, ctrl_tab[sync_seq[k]]}); k++;
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({GUARD_CH, GUARD_CH, terc4_tab[{2'b11, sync_seq[k]}]}); k++;
    end
    for (int p = 0; p < n; p++) begin
      h = mq_hdr.pop_front();
      b = mq_body.pop_front();
      hs = {ecc_of({40'b0, h}, 24), h};
      for (int s = 0; s < 4; s++) sub[s] = {ecc_of({8'b0, b[56*s +: 56]}, 56), b[56*s +: 56]};
      for (int j = 0; j < 32; j++) begin
        b3 = !(p == 0 && j == 0);
        c1 = {sub[3][2*j], sub[2][2*j], sub[1][2*j], sub[0][2*j]};
        c2 = {sub[3][2*j+1], sub[2][2*j+1], sub[1][2*j+1], sub[0][2*j+1]};
        exp_q.push_back({terc4_tab[c2], terc4_tab[c1], terc4_tab[{b3, hs[j], sync_seq[k]}]});
        k++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({GUARD_CH, GUARD_CH, terc4_tab[{2'b11, sync_seq[k]}]}); k++;
    end
  endtask

  // start in the current cycle; returns in the first idle cycle after the island
  task automatic run_island(input int sync_fix, input bit extra_push, input bit restart_mid);
    int n, total, first_rdy, r_end;
    logic [23:0]  xh;
    logic [223:0] xb;
    n = (mq_hdr.size() < NPKT_MAX) ? mq_hdr.size() : NPKT_MAX;
    total = (n == 0) ? 0 : 12 + 32 * n;
    for (int i = 0; i < 128; i++)
      sync_seq[i] = (sync_fix < 0) ? 2'($urandom_range(0, 3)) : 2'(sync_fix);
    exp_q.delete();
    obs_d.delete();
    if (n > 0) build_expected(n);
    start = 1'b1;
    {vsync, hsync} = sync_seq[0];
    first_rdy = -1;
    xh = $urandom;
    xb = rand_body();
    if (extra_push) begin
      pkt_valid = 1'b1;
      pkt_hdr   = xh;
      pkt_body  = xb;
      check("ready_when_full", pkt_ready, 0);
    end
    last_len = 0;
    r_end = total + 1 + ((n == 0) ? 3 : 0);
    for (int r = 1; r <= r_end; r++) begin
      step;
      start = (restart_mid && r == 20);
      {vsync, hsync} = sync_seq[r];
      if (extra_push) begin
        if (first_rdy >= 0) pkt_valid = 1'b0;
        else if (pkt_ready) begin
          first_rdy = r;
          mq_hdr.push_back(xh);
          mq_body.push_back(xb);
        end
      end
      if (island_en) last_len++;
      if (r <= total) begin
        check($sformatf("island_en r=%0d", r), island_en, 1);
        check($sformatf("busy r=%0d", r), busy, 1);
        check($sformatf("d r=%0d", r), d, exp_q.pop_front());
        obs_d.push_back(d);
      end else begin
        check($sformatf("island_en_idle r=%0d", r), island_en, 0);
        check($sformatf("busy_idle r=%0d", r), busy, 0);
      end
    end
    start = 1'b0;
    if (extra_push) begin
      check("pop_frees_slot_window", (first_rdy >= 9 && first_rdy <= 11), 1);
      pkt_valid = 1'b0;
    end
  endtask

  initial begin
    int npush;
    terc4_tab = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                  10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                  10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                  10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    ctrl_tab  = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    vecs[0] = '{2'b00, 10'b1101010100, 10'b1010001110, 10'b1010011100, 10'b1011001100};
    vecs[1] = '{2'b01, 10'b0010101011, 10'b1001110001, 10'b1001100011, 10'b0100111001};
    vecs[2] = '{2'b10, 10'b0101010100, 10'b0101100011, 10'b1011100100, 10'b0110011100};
    vecs[3] = '{2'b11, 10'b1010101011, 10'b1011000011, 10'b1011100010, 10'b1011000110};

    rst = 1'b1; start = 1'b0; pkt_valid = 1'b0; hsync = 1'b0; vsync = 1'b0;
    pkt_hdr = '0; pkt_body = '0;
    step; step;
    check("rst_island_en", island_en, 0);
    check("rst_busy", busy, 0);
    check("rst_d", d, 0);
    check("rst_pkt_ready", pkt_ready, 1);
    rst = 1'b0;
    step;

    // all-zero packet under each fixed sync level
    for (int v = 0; v < 4; v++) begin
      push_pkt(24'h0, 224'h0);
      run_island(int'(vecs[v].vh), 0, 0);
      check($sformatf("pre_ch0 v%0d", v), obs_d[0][9:0], vecs[v].pre0);
      check($sformatf("pre_ch1 v%0d", v), obs_d[7][19:10], PRE_CH);
      check($sformatf("guard_ch0 v%0d", v), obs_d[8][9:0], vecs[v].grd0);
      check($sformatf("pkt0_ch0 v%0d", v), obs_d[10][9:0], vecs[v].pkt0);
      check($sformatf("pkt1_ch0 v%0d", v), obs_d[11][9:0], vecs[v].pkt1);
      check($sformatf("pkt31_ch0 v%0d", v), obs_d[41][9:0], vecs[v].pkt1);
      check($sformatf("pkt_ch1 v%0d", v), obs_d[20][19:10], 10'b1010011100);
      check($sformatf("pkt_ch2 v%0d", v), obs_d[40][29:20], 10'b1010011100);
      check($sformatf("len v%0d", v), last_len, 44);
      step;
    end

    // header with non-trivial ECC, random body and random sync every cycle
    push_pkt(24'h0d0282, rand_body());
    run_island(-1, 0, 0);
    step;

    // three queued, two sent, then the third back to back
    for (int i = 0; i < 3; i++) push_pkt($urandom, rand_body());
    run_island(-1, 0, 0);
    check("len_two_pkts", last_len, 76);
    run_island(-1, 0, 0);
    check("len_leftover", last_len, 44);
    step;

    // full FIFO, a fifth packet held across the pop
    for (int i = 0; i < 4; i++) push_pkt($urandom, rand_body());
    check("full_not_ready", pkt_ready, 0);
    run_island(-1, 1, 0);
    run_island(-1, 0, 0);
    run_island(-1, 0, 0);
    check("len_extra_pkt", last_len, 44);
    step;

    // start with nothing queued, then start while busy
    run_island(-1, 0, 0);
    check("empty_start_len", last_len, 0);
    push_pkt($urandom, rand_body());
    run_island(-1, 0, 1);
    step;

    // reset while packet cycle 10 is on d; a queued packet must be dropped
    push_pkt($urandom, rand_body());
    push_pkt($urandom, rand_body());
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 20; i++) step;
    check("en_before_abort", island_en, 1);
    rst = 1'b1;
    step;
    check("abort_island_en", island_en, 0);
    check("abort_busy", busy, 0);
    check("abort_d", d, 0);
    check("abort_pkt_ready", pkt_ready, 1);
    rst = 1'b0;
    mq_hdr.delete();
    mq_body.delete();
    step;
    push_pkt($urandom, rand_body());
    run_island(-1, 0, 0);
    check("clean_after_abort_len", last_len, 44);

    // randomized islands, sometimes back to back, sometimes with a restart pulse
    for (int it = 0; it < 12; it++) begin
      npush = $urandom_range(0, 3);
      if (npush > FIFO_DEPTH - mq_hdr.size()) npush = FIFO_DEPTH - mq_hdr.size();
      for (int i = 0; i < npush; i++) push_pkt($urandom, rand_body());
      for (int g = $urandom_range(0, 2); g > 0; g--) step;
      run_island(-1, 0, ($urandom_range(0, 3) == 0));
    end
    while (mq_hdr.size() > 0) run_island(-1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hdmi_island.md
HDMI_ISLAND -- requirements
Module: hdmi_island

Interface
REQ-001 SHALL have parameter NPKT_MAX, default 2: max packets per data island, legal range 1..18.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: packet FIFO entries, power of 2, at least 2.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port hsync, input, 1: current HSYNC level, carried in the island.
REQ-006 SHALL have port vsync, input, 1: current VSYNC level, carried in the island.
REQ-007 SHALL have port start, input, 1: pulse requesting an island; caller guarantees blanking room.
REQ-008 SHALL have port pkt_valid, input, 1: packet offered.
REQ-009 SHALL have port pkt_ready, output, 1: FIFO can accept a packet.
REQ-010 SHALL have port pkt_hdr, input, 24: packet header HB0..HB2, HB0 in bits 7:0.
REQ-011 SHALL have port pkt_body, input, 224: subpacket k in bits 56k+55:56k, k = 0..3.
REQ-012 SHALL have port island_en, output, 1: d is valid; external mux selects d over video/control.
REQ-013 SHALL have port d, output, 30: registered symbols, {ch2, ch1, ch0} with 10 bits each.
REQ-014 SHALL have port busy, output, 1: an island sequence is in progress.

Function
REQ-015 SHALL push a packet into the FIFO when pkt_valid and pkt_ready; pkt_ready = not full, evaluated before any same-cycle pop.
REQ-016 SHALL, on start while idle with FIFO count C > 0, latch N = min(C, NPKT_MAX); start while busy or with C = 0 SHALL be ignored.
REQ-017 SHALL sequence, counting from the start cycle t0: d/island_en at t0+1..t0+8 preamble; t0+9..t0+10 leading guard; then N×32 packet cycles; then 2 trailing guard; island_en low after. busy is high from t0+1 through the last trailing guard cycle.
REQ-018 Preamble SHALL drive ch1 = ch2 = 0010101011 and ch0 = the control code of {vsync,hsync}: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
REQ-019 Guard SHALL drive ch1 = ch2 = 0100110011 and ch0 = TERC4({1,1,vsync,hsync}).
REQ-020 SHALL pop one FIFO entry per packet, loading it into the shift registers in the cycle before that packet's first symbol; packets are sent in FIFO order.
REQ-021 Packet cycle j (0..31) SHALL drive ch0 = TERC4({b3, hbit_j, vsync, hsync}); b3 = 0 only at j = 0 of the island's first packet, else 1.
REQ-022 hbit_j SHALL be header bit j (LSB first) for j < 24 and header ECC bit j−24 for j ≥ 24.
REQ-023 Packet cycle j SHALL drive ch1 = TERC4({s3[2j], s2[2j], s1[2j], s0[2j]}) and ch2 = TERC4({s3[2j+1], s2[2j+1], s1[2j+1], s0[2j+1]}).
REQ-024 sk[i] SHALL be body bit i for i < 56 and ECC_k bit i−56 for i ≥ 56.
REQ-025 Each ECC SHALL use an 8-bit state e, cleared per packet; per data bit b (LSB first), e ← (e>>1) ^ ((e[0]^b) ? 8'h83 : 0). Subpackets apply this twice per cycle, even bit first.
REQ-026 TERC4 SHALL map 0..F to: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
REQ-027 hsync/vsync SHALL be sampled in the cycle before their symbol appears on d (1-cycle latency).
REQ-028 Packets pushed during an island SHALL NOT extend it; they wait for the next start.
REQ-029 A start in the cycle after the last trailing guard SHALL be accepted, so islands can run back to back.

Reset
REQ-030 While rst is high: island_en = 0, busy = 0, d = 0, FIFO emptied, pkt_ready = 1, sequencer idle.
REQ-031 rst asserted mid-island SHALL abort it: outputs take reset values at the next edge, and the in-flight packet is lost.

Verification
REQ-032 Push one all-zero packet, start with hsync = vsync = 0 → preamble ch0 = 1101010100 ×8; guard ch0 = 1010001110; packet cycle 0 ch0 = 1010011100, cycles 1..31 ch0 = 1011001100; ch1 = ch2 = 1010011100 ×32; island_en high 44 cycles.
REQ-033 Push header 24'h0d0282 with random body; compare ECC symbols against the REQ-025 model → exact match on all 32 cycles of every channel.
REQ-034 NPKT_MAX = 2; push 3 packets then start → two packets sent (76 cycles), FIFO count 1; a second start sends the third packet.
REQ-035 Fill FIFO (4 entries) → pkt_ready = 0; pkt_valid held during a pop cycle is not accepted that cycle and is accepted next cycle.
REQ-036 Start with an empty FIFO, and start while busy → ignored, no change to island_en.
REQ-037 Assert rst at packet cycle 10 → island_en = 0 and pkt_ready = 1 next cycle; a new push then start produces a clean island.
